// File: rtl/fht_seq_ctrl.sv
// Address and strobe sequencer for an in-place 4-bank fast Hartley transform.
// Every output is registered; iHOLD freezes the sequence and masks strobes.
module fht_seq_ctrl #(
    parameter int A_BIT    = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic               iCLK,
    input  logic               iRESET,
    input  logic               iSTART,
    input  logic [3:0]         iNUM_STAGE,
    input  logic               iHOLD,
    output logic               oBUSY,
    output logic               oDONE,
    output logic               oERR,
    output logic [3:0]         oSTAGE,
    output logic               oST_ZERO,
    output logic               oST_LAST,
    output logic [A_BIT-1:0]   oADDR_RD,
    output logic               oRD_EN,
    output logic [A_BIT-1:0]   oADDR_WR,
    output logic               oWE_A,
    output logic               oWE_B,
    output logic [A_BIT-3:0]   oADDR_COEF,
    output logic [A_BIT-1:0]   oSECTOR,
    output logic               oSOURCE_DATA
);
    localparam int MAX_STG = A_BIT + 2;
    localparam int C_BIT   = A_BIT - 2;
    localparam int D_BIT   = $clog2(PIPE_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t           state_reg;
    logic [3:0]       num_stage_reg;
    logic [3:0]       stage_reg;
    logic [A_BIT-1:0] rd_cnt_reg;
    logic [D_BIT-1:0] drain_cnt_reg;
    logic [C_BIT-1:0] coef_cnt_reg;
    logic [C_BIT-1:0] coef_addr_reg;
    logic [A_BIT-1:0] addr_rd_reg;
    logic [A_BIT-1:0] addr_wr_reg;
    logic [A_BIT-1:0] sector_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_reg;
    logic             st_zero_reg;
    logic             st_last_reg;
    logic             rd_en_reg;
    logic             we_a_reg;
    logic             we_b_reg;
    logic             source_reg;

    // Delay line carries the stage parity so write routing follows the read's stage.
    logic             dl_en_reg   [PIPE_LAT];
    logic [A_BIT-1:0] dl_addr_reg [PIPE_LAT];
    logic             dl_par_reg  [PIPE_LAT];

    int unsigned      sh_amt;
    logic [A_BIT-1:0] sec_mask;
    logic [A_BIT-1:0] sector_next;
    logic             sector_end;
    logic             start_legal;
    logic [C_BIT-1:0] coef_rev;

    always_comb begin
        sh_amt = 0;
        if (int'(stage_reg) < A_BIT) begin
            sh_amt = A_BIT - int'(stage_reg);
        end
        sec_mask    = ~({A_BIT{1'b1}} << sh_amt);
        sector_next = rd_cnt_reg >> sh_amt;
        sector_end  = &(rd_cnt_reg | ~sec_mask);
        start_legal = (iNUM_STAGE != 4'd0) && (int'(iNUM_STAGE) <= MAX_STG);
    end

    for (genvar gi = 0; gi < C_BIT; gi++) begin : g_rev
        assign coef_rev[gi] = coef_cnt_reg[C_BIT-1-gi];
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                dl_en_reg[i]   <= 1'b0;
                dl_addr_reg[i] <= '0;
                dl_par_reg[i]  <= 1'b0;
            end
        end else if (!iHOLD) begin
            dl_en_reg[0]   <= (state_reg == S_READ);
            dl_addr_reg[0] <= rd_cnt_reg;
            dl_par_reg[0]  <= stage_reg[0];
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl_en_reg[i]   <= dl_en_reg[i-1];
                dl_addr_reg[i] <= dl_addr_reg[i-1];
                dl_par_reg[i]  <= dl_par_reg[i-1];
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_reg     <= S_IDLE;
            num_stage_reg <= '0;
            stage_reg     <= '0;
            rd_cnt_reg    <= '0;
            drain_cnt_reg <= '0;
            coef_cnt_reg  <= '0;
            coef_addr_reg <= '0;
            addr_rd_reg   <= '0;
            addr_wr_reg   <= '0;
            sector_reg    <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            st_zero_reg   <= 1'b0;
            st_last_reg   <= 1'b0;
            rd_en_reg     <= 1'b0;
            we_a_reg      <= 1'b0;
            we_b_reg      <= 1'b0;
            source_reg    <= 1'b0;
        end else if (iHOLD) begin
            rd_en_reg <= 1'b0;
            we_a_reg  <= 1'b0;
            we_b_reg  <= 1'b0;
        end else begin
            rd_en_reg   <= 1'b0;
            err_reg     <= 1'b0;
            done_reg    <= 1'b0;
            addr_wr_reg <= dl_addr_reg[PIPE_LAT-1];
            we_a_reg    <= dl_en_reg[PIPE_LAT-1] &  dl_par_reg[PIPE_LAT-1];
            we_b_reg    <= dl_en_reg[PIPE_LAT-1] & ~dl_par_reg[PIPE_LAT-1];
            case (state_reg)
                S_IDLE: begin
                    if (iSTART) begin
                        if (start_legal) begin
                            state_reg     <= S_READ;
                            num_stage_reg <= iNUM_STAGE;
                            stage_reg     <= '0;
                            rd_cnt_reg    <= '0;
                            drain_cnt_reg <= '0;
                            coef_cnt_reg  <= '0;
                            source_reg    <= 1'b0;
                            busy_reg      <= 1'b1;
                            st_zero_reg   <= 1'b1;
                            st_last_reg   <= (iNUM_STAGE == 4'd1);
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    rd_en_reg     <= 1'b1;
                    addr_rd_reg   <= rd_cnt_reg;
                    sector_reg    <= sector_next;
                    coef_addr_reg <= coef_rev;
                    if (sector_end) begin
                        coef_cnt_reg <= coef_cnt_reg + C_BIT'(1);
                    end
                    rd_cnt_reg <= rd_cnt_reg + A_BIT'(1);
                    if (rd_cnt_reg == '1) begin
                        state_reg     <= S_DRAIN;
                        drain_cnt_reg <= '0;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_reg == D_BIT'(PIPE_LAT - 1)) begin
                        state_reg <= S_NEXT;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + D_BIT'(1);
                    end
                end
                S_NEXT: begin
                    if (stage_reg == num_stage_reg - 4'd1) begin
                        state_reg <= S_DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg    <= S_READ;
                        stage_reg    <= stage_reg + 4'd1;
                        source_reg   <= ~source_reg;
                        coef_cnt_reg <= '0;
                        st_zero_reg  <= 1'b0;
                        st_last_reg  <= (stage_reg + 4'd2 == num_stage_reg);
                    end
                end
                S_DONE: begin
                    state_reg   <= S_IDLE;
                    busy_reg    <= 1'b0;
                    st_zero_reg <= 1'b0;
                    st_last_reg <= 1'b0;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign oBUSY        = busy_reg;
    assign oDONE        = done_reg;
    assign oERR         = err_reg;
    assign oSTAGE       = stage_reg;
    assign oST_ZERO     = st_zero_reg;
    assign oST_LAST     = st_last_reg;
    assign oADDR_RD     = addr_rd_reg;
    assign oRD_EN       = rd_en_reg;
    assign oADDR_WR     = addr_wr_reg;
    assign oWE_A        = we_a_reg;
    assign oWE_B        = we_b_reg;
    assign oADDR_COEF   = coef_addr_reg;
    assign oSECTOR      = sector_reg;
    assign oSOURCE_DATA = source_reg;
endmodule

// File: tb/tb_fht_seq_ctrl.sv
// Scoreboard bench for fht_seq_ctrl with A_BIT=4, PIPE_LAT=3 (16 reads, 20 cycles per stage).
module tb_fht_seq_ctrl;
    localparam int A_BIT    = 4;
    localparam int PIPE_LAT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] num;
    logic       hold;

    logic       busy, done, err, st_zero, st_last, rd_en, we_a, we_b, source;
    logic [3:0] stage, addr_rd, addr_wr, sector;
    logic [1:0] addr_coef;

    fht_seq_ctrl #(.A_BIT(A_BIT), .PIPE_LAT(PIPE_LAT)) dut (
        .iCLK(clk), .iRESET(rst), .iSTART(start), .iNUM_STAGE(num), .iHOLD(hold),
        .oBUSY(busy), .oDONE(done), .oERR(err), .oSTAGE(stage),
        .oST_ZERO(st_zero), .oST_LAST(st_last), .oADDR_RD(addr_rd), .oRD_EN(rd_en),
        .oADDR_WR(addr_wr), .oWE_A(we_a), .oWE_B(we_b), .oADDR_COEF(addr_coef),
        .oSECTOR(sector), .oSOURCE_DATA(source)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] addr;
        logic [3:0] stg;
        logic [3:0] sec;
        logic [1:0] coef;
        logic       src;
        logic       zero;
        logic       last;
    } rd_t;

    typedef struct packed {
        logic [3:0] addr;
        logic       a;
        logic       b;
    } wr_t;

    rd_t  rdq[$];
    wr_t  wrq[$];
    rd_t  rd_exp;
    wr_t  wr_exp;
    int   errors = 0;
    int   checks = 0;
    int   n_rd = 0, n_wa = 0, n_wb = 0;
    bit   lat_chk = 1'b0;
    logic hold_q = 1'b0;
    logic [4:0] hist [3];
    logic [26:0] all_out;

    assign all_out = {busy, done, err, stage, st_zero, st_last, addr_rd, rd_en,
                      addr_wr, we_a, we_b, addr_coef, sector, source};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference sequence: sector = addr >> sh, coefficient = completed sectors mod 4, bit-reversed.
    task automatic push_run(input int n);
        for (int s = 0; s < n; s++) begin
            int sh;
            sh = (s >= A_BIT) ? 0 : A_BIT - s;
            for (int a = 0; a < 16; a++) begin
                rd_t r;
                wr_t w;
                logic [3:0] sec;
                logic [1:0] c;
                sec    = 4'(a >> sh);
                c      = sec[1:0];
                r.addr = 4'(a);
                r.stg  = 4'(s);
                r.sec  = sec;
                r.coef = {c[0], c[1]};
                r.src  = s[0];
                r.zero = (s == 0);
                r.last = (s == n - 1);
                rdq.push_back(r);
                w.addr = 4'(a);
                w.a    = s[0];
                w.b    = ~s[0];
                wrq.push_back(w);
            end
        end
    endtask

    always @(posedge clk) hold_q <= hold;

    always @(negedge clk) begin
        if (!rst) begin
            if (rd_en) begin
                n_rd++;
                chk("rd_queue_nonempty", 32'(rdq.size() != 0), 1);
                if (rdq.size() != 0) begin
                    rd_exp = rdq.pop_front();
                    chk("rd_txn", 32'({addr_rd, stage, sector, addr_coef, source, st_zero, st_last}),
                        32'(rd_exp));
                end
            end
            if (we_a || we_b) begin
                if (we_a) n_wa++;
                if (we_b) n_wb++;
                chk("wr_queue_nonempty", 32'(wrq.size() != 0), 1);
                if (wrq.size() != 0) begin
                    wr_exp = wrq.pop_front();
                    chk("wr_txn", 32'({addr_wr, we_a, we_b}), 32'(wr_exp));
                end
                if (lat_chk) chk("wr_latency", 32'({1'b1, addr_wr}), 32'(hist[2]));
            end
            if (hold_q) chk("hold_quiet", 32'({rd_en, we_a, we_b}), 0);
        end
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = {rd_en, addr_rd};
    end

    // Waits for oDONE; optionally pulses iSTART mid-run and injects a hold at a given read.
    task automatic run_wait(input int poke_at, input int h_stage, input int h_addr,
                            input int h_len, output int len, output bit seen);
        int  hold_left;
        bit  hold_used;
        len       = 0;
        seen      = 1'b0;
        hold_left = 0;
        hold_used = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            start = (len == poke_at);
            if (len == poke_at) num = 4'd1;
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) hold = 1'b0;
            end else if (!hold_used && h_stage >= 0 && rd_en &&
                         int'(stage) == h_stage && int'(addr_rd) == h_addr) begin
                hold      = 1'b1;
                hold_left = h_len;
                hold_used = 1'b1;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) len++;
        end
        start = 1'b0;
    endtask

    initial begin
        int len;
        bit seen;
        bit found;
        rst   = 1'b1;
        start = 1'b0;
        hold  = 1'b0;
        num   = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(all_out), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", 32'(all_out), 0);

        // Illegal stage counts: 0 and MAX_STG+1
        for (int k = 0; k < 2; k++) begin
            num   = (k == 0) ? 4'd0 : 4'd7;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("err_pulse", 32'({err, busy}), 32'(2'b10));
            @(negedge clk);
            chk("err_clear", 32'({err, busy}), 0);
            $display("reject num=%0d err pulse observed=%0b", num, err);
        end

        // Full 6-stage run, with a stray start pulse while busy
        lat_chk = 1'b1;
        push_run(6);
        num   = 4'd6;
        start = 1'b1;
        run_wait(50, -1, 0, 0, len, seen);
        chk("run6_done_seen", 32'(seen), 1);
        chk("run6_len", 32'(len), 120);
        chk("run6_done_busy", 32'({done, busy}), 32'(2'b11));
        @(negedge clk);
        chk("run6_post_done", 32'({done, busy, st_zero, st_last}), 0);
        chk("run6_queues_empty", 32'(rdq.size() + wrq.size()), 0);
        $display("run num=6 len=%0d", len);
        lat_chk = 1'b0;

        // Two stages with a 5-cycle hold at read 7 of stage 1
        push_run(2);
        num   = 4'd2;
        start = 1'b1;
        run_wait(-1, 1, 7, 5, len, seen);
        chk("hold_done_seen", 32'(seen), 1);
        chk("hold_len", 32'(len), 45);
        @(negedge clk);
        chk("hold_queues_empty", 32'(rdq.size() + wrq.size()), 0);
        $display("run num=2 hold=5 len=%0d", len);

        // Reset in the drain of stage 3, then a clean single-stage restart
        push_run(6);
        num   = 4'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (rd_en && stage == 4'd3 && addr_rd == 4'd15) begin
                found = 1'b1;
                break;
            end
        end
        chk("stage3_last_read_found", 32'(found), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_reset_outputs", 32'(all_out), 0);
        rdq.delete();
        wrq.delete();
        n_rd = 0;
        n_wa = 0;
        n_wb = 0;
        rst  = 1'b0;
        push_run(1);
        @(negedge clk);
        num   = 4'd1;
        start = 1'b1;
        run_wait(-1, -1, 0, 0, len, seen);
        chk("restart_done_seen", 32'(seen), 1);
        chk("restart_len", 32'(len), 20);
        @(negedge clk);
        chk("restart_reads", 32'(n_rd), 16);
        chk("restart_we_b", 32'(n_wb), 16);
        chk("restart_we_a", 32'(n_wa), 0);
        chk("restart_queues_empty", 32'(rdq.size() + wrq.size()), 0);
        $display("run num=1 after reset len=%0d reads=%0d we_b=%0d", len, n_rd, n_wb);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
